lcd_ctrl: RTL and testbench
===========================

# lcd_ctrl

Timing engine for the HD44780-compatible character LCD. It sits directly downstream of the memory-mapped output peripheral: a CPU store to the LCD register yields a one-cycle write strobe plus a {RS, DB} byte. The block buffers that byte and generates the setup/enable/hold/execution-time sequence on the 12-bit LCD pin bundle. After reset it runs the power-on initialisation sequence on its own and reports busy status for software polling.

## Interface
- `PWR_CYC`, default 2_000_000: power-on wait, 40 ms at 50 MHz.
- `SETUP_CYC`, default 4: RS/DB valid before EN rises.
- `EN_CYC`, default 12: EN high width.
- `HOLD_CYC`, default 4: RS/DB held after EN falls.
- `EXEC_CYC`, default 1_850: normal command/data execution wait, 37 µs.
- `LONG_CYC`, default 76_000: clear/home execution wait, 1.52 ms.

- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `wr_en_i`  in  1  one-cycle write strobe from LCD register store.
- `wr_data_i`  in  9  bit 8 = RS, bits 7:0 = DB.
- `on_i`  in  1  backlight/power enable, registered onto the ON pin.
- `busy_o`  out  1  high while initialising, transferring, or holding a pending byte.
- `ovf_o`  out  1  sticky: a write was dropped because the buffer was full. Cleared only by reset.
- `o_io_lcd`  out  12  bit 11 = ON, 10 = EN, 9 = RS, 8 = RW (always 0), 7:0 = DB.

## Operation
- One-entry pending buffer, fields `pend_valid` and `pend_data[8:0]`.
  - `wr_en_i` is accepted when `pend_valid` = 0, or when the buffer is drained in the same cycle.
  - Otherwise the write is dropped and `ovf_o` is set.
- FSM states: PWR_WAIT, IDLE, SETUP, PULSE, HOLD, EXEC.
  - **PWR_WAIT:** count `PWR_CYC` cycles, then go to SETUP with init step 0.
  - **IDLE:** if `init_step` < 4, issue the next init ROM byte. Else, if `pend_valid`, latch `pend_data` into the output byte, clear the buffer, and go to SETUP.
  - **SETUP** (`SETUP_CYC` cycles) → **PULSE** (EN=1, `EN_CYC` cycles) → **HOLD** (EN=0, `HOLD_CYC` cycles) → **EXEC** → IDLE.
  - EXEC lasts `LONG_CYC` when RS=0 and DB[7:2]=0 (clear or home). Otherwise it lasts `EXEC_CYC`.
- Init ROM, all with RS=0: 0x38, 0x0C, 0x01, 0x06. `init_step` increments on leaving EXEC for each init byte.
- Writes arriving during init are buffered or dropped by the normal rule and issued after init completes.
- `busy_o` = (state ≠ IDLE) | `pend_valid` | (`init_step` < 4).
- RS and DB change only on entry to SETUP and are stable through HOLD. RW is tied to 0.

## Timing
- **Reset values:** state = PWR_WAIT, `init_step` = 0, `pend_valid` = 0, `ovf_o` = 0, `o_io_lcd` = 12'h000, `busy_o` = 1.
- **Reset mid-transfer:** EN drops asynchronously to 0 and the full init sequence restarts. Buffered data is lost.
- Every output is registered. The ON bit follows `on_i` with 1-cycle latency.
- **Latency, idle with empty buffer:** strobe at edge N → `pend_valid` at N+1 → SETUP from N+2 → EN rises at N+2+`SETUP_CYC` → EN falls `EN_CYC` cycles later → back in IDLE after HOLD + EXEC.
- Phase counts are exact. Counter width is $clog2 of the largest parameter, and the counter reloads to parameter−1 on each state entry.
- **Simultaneous IDLE drain and `wr_en_i`:** the new byte is accepted and `ovf_o` is unchanged.

## Structure
- Package `lcd_pkg` holds:
  - the state enum,
  - the init ROM constant array,
  - pin bit-index constants (ON = 11, EN = 10, RS = 9, RW = 8),
  - the clear/home decode function.
- One sub-module, `lcd_timer`: a loadable down-counter with a `done` pulse, shared by all timed states.

## Test plan
All scenarios use bench parameters PWR=10, SETUP=2, EN=4, HOLD=2, EXEC=5, LONG=20.
- **Reset/init:** release `rst_i` → exactly four EN pulses carrying DB 0x38, 0x0C, 0x01, 0x06 with RS=0. The gap after 0x01 is 20 EXEC cycles. `busy_o` falls after the last EXEC.
- **Data write:** after init, write 9'h141 → `busy_o` rises the next cycle. RS=1 and DB=0x41 appear 2 cycles before EN; EN is high exactly 4 cycles; EXEC is 5 cycles.
- **Back-to-back:** three strobes on consecutive cycles while idle → first and second bytes are transferred in order, third is dropped, `ovf_o` = 1 and stays 1.
- **Drain collision:** strobe in the same cycle IDLE drains the buffer → accepted, `ovf_o` stays 0.
- **Reset mid-PULSE:** assert `rst_i` while EN=1 → EN=0 immediately, `o_io_lcd` = 0, and the init sequence reruns after release.
- **`on_i`:** toggle `on_i` → bit 11 follows one cycle later, independent of FSM state.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780 character-LCD timing engine.
//   - lcd_state_e    : controller FSM states
//   - PIN_*          : bit positions inside the 12-bit LCD pin bundle
//   - INIT_ROM       : power-on initialisation command bytes (all RS=0)
//   - is_clear_home  : identifies commands that need the long execution wait
//   - max_of         : helper used to size the shared phase counter
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_e;

    // Pin bundle layout: {ON, EN, RS, RW, DB[7:0]}
    localparam int PIN_ON = 11;
    localparam int PIN_EN = 10;
    localparam int PIN_RS = 9;
    localparam int PIN_RW = 8;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    localparam logic [2:0] INIT_LEN = 3'd4;
    localparam logic [7:0] INIT_ROM [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear (0x01) and return-home (0x02/0x03) are the only instructions
    // with DB[7:2] all zero; both need the long execution wait.
    function automatic logic is_clear_home(input logic [8:0] rs_db);
        return !rs_db[8] && (rs_db[7:2] == 6'd0);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every timed phase of lcd_ctrl.
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset, counter reloads RST_VAL
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : phase length minus one
//   done     : high while the count has reached zero
// A phase loaded with N-1 therefore lasts exactly N cycles before done.
module lcd_timer
    import lcd_pkg::*;
#(
    parameter int            CW      = 8,
    parameter logic [CW-1:0] RST_VAL = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= RST_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: timing engine for an HD44780-compatible character LCD.
// Runs the power-on init sequence by itself, then transfers bytes written
// by the CPU through a one-entry pending buffer.
//   clk_i     : system clock
//   rst_i     : asynchronous active-high reset (restarts init, drops buffer)
//   wr_en_i   : one-cycle write strobe from the LCD register store
//   wr_data_i : {RS, DB[7:0]}
//   on_i      : backlight/power enable, registered onto the ON pin
//   busy_o    : initialising, transferring, or holding a pending byte
//   ovf_o     : sticky, a write was dropped because the buffer was full
//   o_io_lcd  : {ON, EN, RS, RW(=0), DB[7:0]}
// Handshake: a write is accepted on any cycle wr_en_i is high and the buffer
// is empty or being drained that same cycle; otherwise it is dropped and
// ovf_o is set. Software polls busy_o before writing to avoid drops.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int PWR_CYC   = 2_000_000,
    parameter int SETUP_CYC = 4,
    parameter int EN_CYC    = 12,
    parameter int HOLD_CYC  = 4,
    parameter int EXEC_CYC  = 1_850,
    parameter int LONG_CYC  = 76_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_en_i,
    input  logic [8:0]  wr_data_i,
    input  logic        on_i,
    output logic        busy_o,
    output logic        ovf_o,
    output logic [11:0] o_io_lcd
);

    localparam int MAXP = max_of(max_of(max_of(PWR_CYC, SETUP_CYC), max_of(EN_CYC, HOLD_CYC)),
                                 max_of(EXEC_CYC, LONG_CYC));
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] LD_PWR   = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] LD_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LD_EN    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(LONG_CYC - 1);

    lcd_state_e    state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic          pend_valid_q, pend_valid_d;
    logic [8:0]    pend_data_q, pend_data_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic          en_q, en_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;
    logic          on_q;

    logic          init_done;
    logic          drain;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;

    // Reset value makes PWR_WAIT last PWR_CYC cycles without an explicit load.
    lcd_timer #(
        .CW      (CW),
        .RST_VAL (LD_PWR)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign init_done = (step_q >= INIT_LEN);

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        rs_d         = rs_q;
        db_d         = db_q;
        en_d         = en_q;
        ovf_d        = ovf_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        drain        = 1'b0;

        case (state_q)
            PWR_WAIT: begin
                if (tmr_done) begin
                    state_d  = SETUP;
                    step_d   = 3'd0;
                    rs_d     = 1'b0;
                    db_d     = INIT_ROM[0];
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end
            end
            IDLE: begin
                if (!init_done) begin
                    state_d  = SETUP;
                    rs_d     = 1'b0;
                    db_d     = INIT_ROM[step_q[1:0]];
                    tmr_load = 1'b1;
                    tmr_val  = LD_SETUP;
                end else if (pend_valid_q) begin
                    drain        = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = SETUP;
                    {rs_d, db_d} = pend_data_q;
                    tmr_load     = 1'b1;
                    tmr_val      = LD_SETUP;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    state_d  = PULSE;
                    en_d     = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EN;
                end
            end
            PULSE: begin
                if (tmr_done) begin
                    state_d  = HOLD;
                    en_d     = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_HOLD;
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    state_d  = EXEC;
                    tmr_load = 1'b1;
                    tmr_val  = is_clear_home({rs_q, db_q}) ? LD_LONG : LD_EXEC;
                end
            end
            EXEC: begin
                if (tmr_done) begin
                    state_d = IDLE;
                    // Only init bytes are issued while init is incomplete,
                    // so every EXEC exit before then retires one ROM entry.
                    if (!init_done) begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = PWR_WAIT;
            end
        endcase

        // Applied after the drain so a same-cycle write refills the buffer.
        if (wr_en_i) begin
            if (!pend_valid_q || drain) begin
                pend_valid_d = 1'b1;
                pend_data_d  = wr_data_i;
            end else begin
                ovf_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE) || pend_valid_d || (step_d < INIT_LEN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= PWR_WAIT;
            step_q       <= 3'd0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= 9'd0;
            rs_q         <= 1'b0;
            db_q         <= 8'd0;
            en_q         <= 1'b0;
            ovf_q        <= 1'b0;
            busy_q       <= 1'b1;
            on_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            rs_q         <= rs_d;
            db_q         <= db_d;
            en_q         <= en_d;
            ovf_q        <= ovf_d;
            busy_q       <= busy_d;
            on_q         <= on_i;
        end
    end

    always_comb begin
        o_io_lcd         = 12'h000;
        o_io_lcd[PIN_ON] = on_q;
        o_io_lcd[PIN_EN] = en_q;
        o_io_lcd[PIN_RS] = rs_q;
        o_io_lcd[PIN_RW] = 1'b0;
        o_io_lcd[7:0]    = db_q;
    end

    assign busy_o = busy_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: self-checking bench for lcd_ctrl with short phase parameters.
// Expected pulses ({exec_cycles, RS, DB}) are queued by the stimulus; a
// monitor pops one per EN rising edge and checks data, setup, EN width and
// the hold+exec gap that follows.
module tb_lcd_ctrl;

    localparam int PWR   = 10;
    localparam int SETUP = 2;
    localparam int ENW   = 4;
    localparam int HOLD  = 2;
    localparam int EXEC  = 5;
    localparam int LONG  = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [8:0]  wr_data;
    logic        on;
    logic        busy;
    logic        ovf;
    logic [11:0] io;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    lcd_ctrl #(
        .PWR_CYC   (PWR),
        .SETUP_CYC (SETUP),
        .EN_CYC    (ENW),
        .HOLD_CYC  (HOLD),
        .EXEC_CYC  (EXEC),
        .LONG_CYC  (LONG)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_data),
        .on_i      (on),
        .busy_o    (busy),
        .ovf_o     (ovf),
        .o_io_lcd  (io)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [8:0] d, input logic [7:0] ex);
        exp_q.push_back({ex, d});
    endtask

    task automatic write(input logic [8:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout busy still high after %0d cycles", name, budget);
        end
    endtask

    task automatic push_init();
        push(9'h038, 8'(EXEC));
        push(9'h00C, 8'(EXEC));
        push(9'h001, 8'(LONG));
        push(9'h006, 8'(EXEC));
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        en_prev;
    logic [9:0]  prev_cur;
    logic [9:0]  cur;
    logic [16:0] e;
    logic        armed;
    int          stable_cnt;
    int          en_width;
    int          fall_cyc;
    int          exp_exec;
    int          cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            en_prev    = 1'b0;
            prev_cur   = 10'd0;
            stable_cnt = 0;
            en_width   = 0;
            armed      = 1'b0;
        end else begin
            cur = io[9:0];
            if (cur == prev_cur) stable_cnt++;
            else stable_cnt = 1;

            // After EN falls: either busy drops (nothing follows) or the next
            // byte appears one IDLE cycle after EXEC ends.
            if (armed) begin
                if (!busy) begin
                    chk("exec_to_idle", cyc - fall_cyc, HOLD + exp_exec);
                    armed = 1'b0;
                end else if (cur != prev_cur) begin
                    chk("exec_to_next", cyc - fall_cyc, HOLD + exp_exec + 1);
                    armed = 1'b0;
                end
            end

            if (io[10] && !en_prev) begin
                en_width = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse actual=%0h expected=none", cur);
                    exp_exec = EXEC;
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_data", int'(cur), int'({e[8], 1'b0, e[7:0]}));
                    exp_exec = int'(e[16:9]);
                end
                chk("setup_cycles", stable_cnt, SETUP + 1);
            end else if (io[10]) begin
                en_width++;
                chk("en_data_stable", int'(cur), int'(prev_cur));
            end else if (en_prev) begin
                chk("en_width", en_width, ENW);
                fall_cyc = cyc;
                armed    = 1'b1;
            end

            en_prev  = io[10];
            prev_cur = cur;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 9'd0;
        on      = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_io", int'(io), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_ovf", int'(ovf), 0);

        // Power-on init
        push_init();
        rst = 1'b0;
        wait_idle("init", 400);
        chk("init_queue_empty", exp_q.size(), 0);
        chk("init_ovf", int'(ovf), 0);

        // Single data write, busy must rise the cycle after the strobe
        push(9'h141, 8'(EXEC));
        write(9'h141);
        chk("busy_after_write", int'(busy), 1);
        wait_idle("data", 200);

        // Execution-time decode boundaries
        push(9'h002, 8'(LONG));
        write(9'h002);
        wait_idle("home", 200);
        push(9'h004, 8'(EXEC));
        write(9'h004);
        wait_idle("entry", 200);
        push(9'h101, 8'(EXEC));
        write(9'h101);
        wait_idle("rs_data", 200);
        chk("writes_queue_empty", exp_q.size(), 0);

        // Drain collision: second strobe lands as IDLE drains the first
        push(9'h150, 8'(EXEC));
        push(9'h151, 8'(EXEC));
        @(negedge clk);
        wr_en = 1'b1; wr_data = 9'h150;
        @(negedge clk);
        wr_data = 9'h151;
        @(negedge clk);
        wr_en = 1'b0;
        chk("collision_ovf_now", int'(ovf), 0);
        wait_idle("collision", 200);
        chk("collision_ovf", int'(ovf), 0);
        chk("collision_queue_empty", exp_q.size(), 0);

        // Back-to-back: third strobe finds the buffer full
        push(9'h142, 8'(EXEC));
        push(9'h143, 8'(EXEC));
        @(negedge clk);
        wr_en = 1'b1; wr_data = 9'h142;
        @(negedge clk);
        wr_data = 9'h143;
        @(negedge clk);
        wr_data = 9'h144;
        @(negedge clk);
        wr_en = 1'b0;
        chk("b2b_ovf_set", int'(ovf), 1);
        wait_idle("b2b", 200);
        chk("b2b_ovf_sticky", int'(ovf), 1);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // ON pin latency while idle
        @(negedge clk);
        on = 1'b1;
        #1;
        chk("on_before_edge", int'(io[11]), 0);
        @(negedge clk);
        chk("on_rise", int'(io[11]), 1);
        on = 1'b0;
        @(negedge clk);
        chk("on_fall", int'(io[11]), 0);

        // Reset in the middle of PULSE, toggling ON during the transfer
        push(9'h155, 8'(EXEC));
        write(9'h155);
        n = 0;
        while (!io[10] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pulse", int'(io[10]), 1);
        on = 1'b1;
        @(negedge clk);
        chk("on_mid_pulse", int'(io[11]), 1);
        chk("en_mid_pulse", int'(io[10]), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_io", int'(io), 0);
        chk("mid_rst_busy", int'(busy), 1);
        chk("mid_rst_ovf", int'(ovf), 0);
        @(negedge clk);
        push_init();
        rst = 1'b0;
        @(negedge clk);
        chk("on_after_rst", int'(io[11]), 1);
        wait_idle("reinit", 400);
        chk("reinit_queue_empty", exp_q.size(), 0);
        chk("reinit_ovf", int'(ovf), 0);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
